// File: rtl/quad_pkg.sv
// Shared types for quad_solver and its neighbours: word defaults, root
// classification enum and the parallel result record.
package quad_pkg;

    localparam int QUAD_WIDTH = 32;
    localparam int QUAD_SCALE = 16;

    typedef enum logic [1:0] {
        REAL     = 2'd0,
        REPEATED = 2'd1,
        COMPLEX  = 2'd2
    } root_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W1   = 2'd1,
        W2   = 2'd2,
        W3   = 2'd3
    } cap_state_t;

    typedef struct packed {
        logic signed [QUAD_WIDTH-1:0] r1;
        logic signed [QUAD_WIDTH-1:0] im1;
        logic signed [QUAD_WIDTH-1:0] r2;
        logic signed [QUAD_WIDTH-1:0] im2;
        root_type_t                   root_type;
    } quad_rec_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; a push while full is taken
// only when a pop frees the head in the same cycle.
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop, w_push;

    // Wrap modulo DEPTH explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/quad_result_collector.sv
// Deserializes the solver's four-word root burst into one record, classifies
// the roots and buffers records behind a valid/ready output.
module quad_result_collector
    import quad_pkg::*;
#(
    parameter int WIDTH = QUAD_WIDTH,
    parameter int SCALE = QUAD_SCALE,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rdy,
    input  logic signed [WIDTH-1:0]    din,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [WIDTH-1:0]    r1,
    output logic signed [WIDTH-1:0]    im1,
    output logic signed [WIDTH-1:0]    r2,
    output logic signed [WIDTH-1:0]    im2,
    output logic [1:0]                 root_type,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int RW = 4*WIDTH + 2;

    if (SCALE >= WIDTH) begin : g_scale_chk
        $fatal(1, "SCALE must be smaller than WIDTH");
    end

    cap_state_t              r_state, w_next;
    logic                    r_rdy_q;
    logic signed [WIDTH-1:0] r_r1, r_im1, r_r2;
    logic                    w_start, w_cap_r1, w_cap_im1, w_cap_r2, w_push;
    root_type_t              w_type;
    logic [RW-1:0]           w_rec, w_head;
    logic                    w_full, w_empty, w_pop;
    logic                    r_overflow;

    // rdy_q resets high so a rdy held through reset is not seen as a rise.
    assign w_start = rdy & ~r_rdy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_rdy_q <= 1'b1;
        end else begin
            r_state <= w_next;
            r_rdy_q <= rdy;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = W1;
            W1:      w_next = W2;
            W2:      w_next = W3;
            W3:      w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_cap_r1  = 1'b0;
        w_cap_im1 = 1'b0;
        w_cap_r2  = 1'b0;
        w_push    = 1'b0;
        case (r_state)
            IDLE:    w_cap_r1  = w_start;
            W1:      w_cap_im1 = 1'b1;
            W2:      w_cap_r2  = 1'b1;
            W3:      w_push    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_r1  <= '0;
            r_im1 <= '0;
            r_r2  <= '0;
        end else begin
            if (w_cap_r1)  r_r1  <= din;
            if (w_cap_im1) r_im1 <= din;
            if (w_cap_r2)  r_r2  <= din;
        end
    end

    // im2 is still on din in W3, so it joins the record directly.
    always_comb begin
        if (r_im1 == '0 && din == '0) w_type = (r_r1 == r_r2) ? REPEATED : REAL;
        else                          w_type = COMPLEX;
    end

    assign w_rec = {r_r1, r_im1, r_r2, din, w_type};
    assign w_pop = out_valid & out_ready;

    sync_fifo #(.DW(RW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_rec),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (reset)                           r_overflow <= 1'b0;
        else if (w_push & w_full & ~w_pop)   r_overflow <= 1'b1;
    end

    assign out_valid = ~w_empty;
    assign overflow  = r_overflow;
    assign {r1, im1, r2, im2, root_type} = w_head;

endmodule

// File: tb/tb_quad_result_collector.sv
// Scoreboard bench for quad_result_collector: expected records are queued as
// bursts are driven and checked at the head every cycle.
module tb_quad_result_collector;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH+1);

    logic                    clk = 1'b0;
    logic                    reset, rdy, out_ready;
    logic signed [WIDTH-1:0] din;
    logic                    out_valid, overflow;
    logic signed [WIDTH-1:0] r1, im1, r2, im2;
    logic [1:0]              root_type;
    logic [CW-1:0]           count;

    typedef struct {
        logic [31:0] r1, im1, r2, im2;
        logic [1:0]  rt;
    } exp_t;

    exp_t sbq[$];
    exp_t none = '{32'd0, 32'd0, 32'd0, 32'd0, 2'd0};
    bit   m_ovf = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    quad_result_collector #(.WIDTH(WIDTH), .SCALE(16), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .rdy       (rdy),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r1        (r1),
        .im1       (im1),
        .r2        (r2),
        .im2       (im2),
        .root_type (root_type),
        .count     (count),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] cls(input logic [31:0] a, b, c, e);
        if (b == 0 && e == 0) return (a == c) ? 2'd1 : 2'd0;
        return 2'd2;
    endfunction

    // Check the outputs left by the last edge, drive the next inputs, then
    // advance the model to what the coming edge should produce.
    task automatic step(input logic rst_v, input logic rdy_v, input logic [31:0] d,
                        input logic ordy_v, input logic push_v, input exp_t rec);
        bit pop;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
        chk("count", 32'(count), sbq.size());
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (sbq.size() != 0) begin
            chk("r1", r1, sbq[0].r1);
            chk("im1", im1, sbq[0].im1);
            chk("r2", r2, sbq[0].r2);
            chk("im2", im2, sbq[0].im2);
            chk("root_type", 32'(root_type), 32'(sbq[0].rt));
        end
        reset = rst_v; rdy = rdy_v; din = d; out_ready = ordy_v;
        pop = (sbq.size() != 0) && ordy_v;
        if (pop) sbq.pop_front();
        if (push_v) begin
            if (sbq.size() == DEPTH) m_ovf = 1'b1;
            else                     sbq.push_back(rec);
        end
        if (rst_v) begin
            sbq.delete();
            m_ovf = 1'b0;
        end
    endtask

    task automatic burst(input logic [31:0] a, b, c, e, input logic [3:0] o);
        exp_t rec;
        rec = '{a, b, c, e, cls(a, b, c, e)};
        step(1'b0, 1'b1, a, o[0], 1'b0, none);
        step(1'b0, 1'b0, b, o[1], 1'b0, none);
        step(1'b0, 1'b0, c, o[2], 1'b0, none);
        step(1'b0, 1'b0, e, o[3], 1'b1, rec);
    endtask

    task automatic idle(input int n, input logic ordy_v);
        repeat (n) step(1'b0, 1'b0, $urandom, ordy_v, 1'b0, none);
    endtask

    initial begin
        reset = 1'b1; rdy = 1'b1; din = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_r1", r1, 32'd0);
        chk("rst_im1", im1, 32'd0);
        chk("rst_r2", r2, 32'd0);
        chk("rst_im2", im2, 32'd0);
        chk("rst_type", 32'(root_type), 32'd0);
        // rdy held high out of reset must not start a capture
        repeat (3) step(1'b0, 1'b1, $urandom, 1'b0, 1'b0, none);
        idle(1, 1'b0);

        // real distinct, then held until drained
        burst(32'h0002_0000, 32'h0, 32'h0001_0000, 32'h0, 4'b0000);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // complex then repeated, back to back with immediate pops
        burst(32'hFFFF_0000, 32'h0002_0000, 32'hFFFF_0000, 32'hFFFE_0000, 4'b1111);
        burst(32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0, 4'b1111);
        burst(32'h1234_5678, 32'h0, 32'h1234_5678, 32'h0000_0001, 4'b1111);
        idle(3, 1'b1);

        // overflow: third record dropped, first two kept in order
        burst(32'h0003_0000, 32'h0, 32'hFFFD_0000, 32'h0, 4'b0000);
        burst(32'h0005_0000, 32'h0, 32'h0005_0000, 32'h0, 4'b0000);
        burst(32'h0007_0000, 32'h0001_0000, 32'h0007_0000, 32'hFFFF_0000, 4'b0000);
        idle(2, 1'b0);
        idle(3, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, none);
        idle(2, 1'b0);

        // full with a pop on the im2 cycle: push accepted, no overflow
        burst(32'h0011_0000, 32'h0, 32'h0022_0000, 32'h0, 4'b0000);
        burst(32'h0033_0000, 32'h0, 32'h0033_0000, 32'h0, 4'b0000);
        burst(32'h0044_0000, 32'h0001_0000, 32'h0055_0000, 32'h0, 4'b1000);
        idle(1, 1'b0);
        idle(4, 1'b1);

        // reset while in W2 with rdy held high through and after reset
        step(1'b0, 1'b1, 32'h0009_0000, 1'b1, 1'b0, none);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, none);
        step(1'b1, 1'b1, 32'h0008_0000, 1'b1, 1'b0, none);
        repeat (5) step(1'b0, 1'b1, $urandom, 1'b1, 1'b0, none);
        idle(2, 1'b1);
        burst(32'hFFF0_0000, 32'h0, 32'h000F_0000, 32'h0, 4'b0000);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // level rdy for 8 cycles: exactly one record
        step(1'b0, 1'b1, 32'h0006_0000, 1'b0, 1'b0, none);
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, none);
        step(1'b0, 1'b1, 32'h0006_0000, 1'b0, 1'b0, none);
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1,
             '{32'h0006_0000, 32'h0, 32'h0006_0000, 32'h0, 2'd1});
        repeat (4) step(1'b0, 1'b1, $urandom, 1'b0, 1'b0, none);
        idle(3, 1'b0);
        idle(3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
